// File: rtl/state_menu_ctrl.sv
// Song-menu controller: debounced button front end feeding a
// START/MENU/PLAY/PAUSE/FINISH state machine with song selection.
module state_menu_ctrl #(
  parameter int N_BUTTONS       = 3,
  parameter int N_SONGS         = 3,
  parameter int DEBOUNCE_CYCLES = 4,
  localparam int SEL_W          = $clog2(N_SONGS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_BUTTONS-1:0] buttons,
  input  logic                 finish,
  output logic [1:0]           state,
  output logic                 paused,
  output logic [SEL_W-1:0]     song_select,
  output logic [SEL_W-1:0]     song_confirm,
  output logic                 confirm_pulse,
  output logic [N_BUTTONS-1:0] btn_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [2:0] {
    S_START,
    S_MENU,
    S_PLAY,
    S_PAUSE,
    S_FINISH
  } state_t;

  logic [N_BUTTONS-1:0] sync1, sync2, stable, pulse;
  logic [CNT_W-1:0]     cnt [N_BUTTONS];

  state_t           cur, nxt;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] conf_q, conf_d;
  logic             cp_q, cp_d;

  logic cmd_prev, cmd_next, cmd_sel;

  // Synchronise, debounce and edge-detect every button
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= '0;
      sync2  <= '0;
      stable <= '0;
      pulse  <= '0;
      for (int unsigned i = 0; i < N_BUTTONS; i++) cnt[i] <= '0;
    end else begin
      sync1 <= buttons;
      sync2 <= sync1;
      for (int unsigned i = 0; i < N_BUTTONS; i++) begin
        pulse[i] <= 1'b0;
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          // this edge completes the run of differing samples, so the flip
          // and its rising-edge strobe are registered together
          stable[i] <= ~stable[i];
          pulse[i]  <= ~stable[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign btn_pulse = pulse;
  assign cmd_prev  = pulse[0];
  assign cmd_next  = pulse[1];
  assign cmd_sel   = pulse[2];

  // FSM, selection and confirm registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cur    <= S_START;
      sel_q  <= SEL_W'(1);
      conf_q <= '0;
      cp_q   <= 1'b0;
    end else begin
      cur    <= nxt;
      sel_q  <= sel_d;
      conf_q <= conf_d;
      cp_q   <= cp_d;
    end
  end

  // Next-state and register updates from the debounced command strobes
  always_comb begin
    nxt    = cur;
    sel_d  = sel_q;
    conf_d = conf_q;
    cp_d   = 1'b0;
    case (cur)
      S_START: begin
        if (|pulse[2:0]) nxt = S_MENU;
      end
      S_MENU: begin
        if (cmd_sel) begin
          nxt    = S_PLAY;
          conf_d = sel_q;
          cp_d   = 1'b1;
        end else if (cmd_next && !cmd_prev) begin
          sel_d = (sel_q == SEL_W'(N_SONGS)) ? SEL_W'(1) : sel_q + SEL_W'(1);
        end else if (cmd_prev && !cmd_next) begin
          sel_d = (sel_q == SEL_W'(1)) ? SEL_W'(N_SONGS) : sel_q - SEL_W'(1);
        end
      end
      S_PLAY: begin
        if (finish)       nxt = S_FINISH;
        else if (cmd_sel) nxt = S_PAUSE;
      end
      S_PAUSE: begin
        if (finish)       nxt = S_FINISH;
        else if (cmd_sel) nxt = S_PLAY;
      end
      S_FINISH: begin
        if (cmd_sel) begin
          nxt    = S_MENU;
          conf_d = '0;
        end
      end
      default: nxt = S_START;
    endcase
  end

  // Externally visible state code; PAUSE shares the PLAY code
  always_comb begin
    state = 2'd0;
    case (cur)
      S_START:  state = 2'd0;
      S_MENU:   state = 2'd1;
      S_PLAY:   state = 2'd2;
      S_PAUSE:  state = 2'd2;
      S_FINISH: state = 2'd3;
      default:  state = 2'd0;
    endcase
  end

  assign paused        = (cur == S_PAUSE);
  assign song_select   = sel_q;
  assign song_confirm  = conf_q;
  assign confirm_pulse = cp_q;

endmodule

// File: tb/tb_state_menu_ctrl.sv
// Self-checking bench for state_menu_ctrl with a behavioural reference model.
module tb_state_menu_ctrl;

  localparam int NB = 3;
  localparam int NS = 3;
  localparam int DB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [NB-1:0] buttons;
  logic          finish;
  logic [1:0]    state;
  logic          paused;
  logic [1:0]    song_select;
  logic [1:0]    song_confirm;
  logic          confirm_pulse;
  logic [NB-1:0] btn_pulse;

  int checks = 0;
  int errors = 0;

  state_menu_ctrl #(
    .N_BUTTONS      (NB),
    .N_SONGS        (NS),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .buttons      (buttons),
    .finish       (finish),
    .state        (state),
    .paused       (paused),
    .song_select  (song_select),
    .song_confirm (song_confirm),
    .confirm_pulse(confirm_pulse),
    .btn_pulse    (btn_pulse)
  );

  always #5 clk = ~clk;

  // Reference model: raw input reaches the debouncer two edges late; the
  // stable level flips once the last DB synchronised samples all disagree.
  int            m_mode;   // 0 start, 1 menu, 2 play, 3 finish, 4 pause
  int            m_sel;
  int            m_conf;
  bit            m_cp;
  bit [NB-1:0]   m_pulse, m_stable, m_d1, m_d2;
  bit [DB-1:0]   m_hist [NB];

  always @(posedge clk) begin
    if (rst) begin
      m_mode = 0; m_sel = 1; m_conf = 0; m_cp = 0;
      m_pulse = '0; m_stable = '0; m_d1 = '0; m_d2 = '0;
      for (int i = 0; i < NB; i++) m_hist[i] = '0;
    end else begin
      m_cp = 0;
      case (m_mode)
        0: if (m_pulse != 0) m_mode = 1;
        1: begin
          if (m_pulse[2]) begin
            m_mode = 2; m_conf = m_sel; m_cp = 1;
          end else if (m_pulse[1] && !m_pulse[0]) begin
            m_sel = m_sel % NS + 1;
          end else if (m_pulse[0] && !m_pulse[1]) begin
            m_sel = (m_sel == 1) ? NS : m_sel - 1;
          end
        end
        2: if (finish) m_mode = 3; else if (m_pulse[2]) m_mode = 4;
        4: if (finish) m_mode = 3; else if (m_pulse[2]) m_mode = 2;
        3: if (m_pulse[2]) begin m_mode = 1; m_conf = 0; end
        default: m_mode = 0;
      endcase
      for (int i = 0; i < NB; i++) begin
        m_hist[i] = {m_hist[i][DB-2:0], m_d2[i]};
        m_pulse[i] = 1'b0;
        if (m_hist[i] == (m_stable[i] ? {DB{1'b0}} : {DB{1'b1}})) begin
          m_stable[i] = ~m_stable[i];
          m_pulse[i]  = m_stable[i];
        end
      end
      m_d2 = m_d1;
      m_d1 = buttons;
    end
  end

  // Press a set of buttons long enough to register, then release and settle
  task automatic tap(input logic [NB-1:0] mask);
    buttons = mask;
    repeat (DB + 4) @(negedge clk);
    buttons = '0;
    repeat (DB + 4) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    buttons = '0;
    finish = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; buttons = '0; finish = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
    checks++; if (paused !== 1'b0) begin errors++; $display("FAIL reset_paused got %0b want 0", paused); end
    checks++; if (song_select !== 2'd1) begin errors++; $display("FAIL reset_select got %0d want 1", song_select); end
    checks++; if (song_confirm !== 2'd0) begin errors++; $display("FAIL reset_confirm got %0d want 0", song_confirm); end
    checks++; if (confirm_pulse !== 1'b0) begin errors++; $display("FAIL reset_cpulse got %0b want 0", confirm_pulse); end
    checks++; if (btn_pulse !== 3'b000) begin errors++; $display("FAIL reset_btnpulse got %b want 000", btn_pulse); end
    rst = 1'b0;
  endtask

  task automatic test_start_confirm();
    int pc, pcnt;
    pc = 0; pcnt = 0;
    buttons = 3'b001;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (btn_pulse[0]) begin pcnt++; pc = c; end
      if (c == 7) begin
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL start_to_menu got %0d want 1", state); end
      end
    end
    checks++; if (pc != DB + 2 || pcnt != 1) begin errors++; $display("FAIL start_pulse_time got cycle %0d count %0d want cycle %0d count 1", pc, pcnt, DB + 2); end
    buttons = '0;
    repeat (DB + 4) @(negedge clk);
    buttons = 3'b100;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 7) begin
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL select_to_play got %0d want 2", state); end
        checks++; if (song_confirm !== 2'd1) begin errors++; $display("FAIL select_confirm got %0d want 1", song_confirm); end
        checks++; if (confirm_pulse !== 1'b1) begin errors++; $display("FAIL cpulse_high got %0b want 1", confirm_pulse); end
      end
      if (c == 8) begin
        checks++; if (confirm_pulse !== 1'b0) begin errors++; $display("FAIL cpulse_one_cycle got %0b want 0", confirm_pulse); end
      end
    end
    buttons = '0;
    repeat (DB + 4) @(negedge clk);
  endtask

  task automatic test_menu_wrap();
    do_reset();
    tap(3'b001);
    checks++; if (state !== 2'd1 || song_select !== 2'd1) begin errors++; $display("FAIL wrap_entry got state %0d sel %0d want 1 1", state, song_select); end
    tap(3'b001);
    checks++; if (song_select !== 2'd3) begin errors++; $display("FAIL wrap_prev got %0d want 3", song_select); end
    tap(3'b010);
    checks++; if (song_select !== 2'd1) begin errors++; $display("FAIL wrap_next got %0d want 1", song_select); end
    tap(3'b010);
    tap(3'b010);
    checks++; if (song_select !== 2'd3) begin errors++; $display("FAIL wrap_next2 got %0d want 3", song_select); end
    tap(3'b011);
    checks++; if (song_select !== 2'd3) begin errors++; $display("FAIL prev_next_same got %0d want 3", song_select); end
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL wrap_stays_menu got %0d want 1", state); end
  endtask

  task automatic test_debounce();
    int pc, pcnt;
    pcnt = 0;
    buttons = 3'b010;
    repeat (3) begin @(negedge clk); if (btn_pulse[1]) pcnt++; end
    buttons = '0;
    repeat (12) begin @(negedge clk); if (btn_pulse[1]) pcnt++; end
    checks++; if (pcnt != 0) begin errors++; $display("FAIL glitch_pulses got %0d want 0", pcnt); end
    pcnt = 0; pc = 0;
    buttons = 3'b010;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (btn_pulse[1]) begin pcnt++; pc = c; end
    end
    buttons = '0;
    repeat (12) begin @(negedge clk); if (btn_pulse[1]) pcnt++; end
    checks++; if (pcnt != 1 || pc != 6) begin errors++; $display("FAIL six_cycle got count %0d at %0d want 1 at 6", pcnt, pc); end
    pcnt = 0;
    buttons = 3'b010;
    repeat (100) begin @(negedge clk); if (btn_pulse[1]) pcnt++; end
    buttons = '0;
    repeat (12) begin @(negedge clk); if (btn_pulse[1]) pcnt++; end
    checks++; if (pcnt != 1) begin errors++; $display("FAIL held_100 got %0d want 1", pcnt); end
  endtask

  task automatic test_pause_finish();
    logic [1:0] keep;
    tap(3'b100);
    checks++; if (state !== 2'd2 || paused !== 1'b0) begin errors++; $display("FAIL play_entry got state %0d paused %0b want 2 0", state, paused); end
    tap(3'b100);
    checks++; if (state !== 2'd2 || paused !== 1'b1) begin errors++; $display("FAIL pause got state %0d paused %0b want 2 1", state, paused); end
    tap(3'b100);
    checks++; if (paused !== 1'b0) begin errors++; $display("FAIL unpause got %0b want 0", paused); end
    keep = song_select;
    buttons = 3'b100;
    repeat (DB + 2) @(negedge clk);
    checks++; if (btn_pulse[2] !== 1'b1) begin errors++; $display("FAIL sel_pulse_time got %0b want 1", btn_pulse[2]); end
    finish = 1'b1;
    @(negedge clk);
    finish = 1'b0;
    checks++; if (state !== 2'd3 || paused !== 1'b0) begin errors++; $display("FAIL finish_wins got state %0d paused %0b want 3 0", state, paused); end
    buttons = '0;
    repeat (DB + 4) @(negedge clk);
    tap(3'b100);
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL finish_to_menu got %0d want 1", state); end
    checks++; if (song_confirm !== 2'd0) begin errors++; $display("FAIL finish_clear got %0d want 0", song_confirm); end
    checks++; if (song_select !== keep) begin errors++; $display("FAIL finish_retain got %0d want %0d", song_select, keep); end
  endtask

  task automatic test_reset_mid();
    int pc;
    do_reset();
    tap(3'b001);
    tap(3'b010);
    tap(3'b100);
    tap(3'b100);
    checks++; if (paused !== 1'b1 || song_confirm !== 2'd2) begin errors++; $display("FAIL mid_setup got paused %0b conf %0d want 1 2", paused, song_confirm); end
    rst = 1'b1;
    buttons = 3'b010;
    @(negedge clk);
    checks++; if (state !== 2'd0 || paused !== 1'b0) begin errors++; $display("FAIL mid_rst_state got %0d paused %0b want 0 0", state, paused); end
    checks++; if (song_select !== 2'd1 || song_confirm !== 2'd0) begin errors++; $display("FAIL mid_rst_sel got %0d conf %0d want 1 0", song_select, song_confirm); end
    repeat (10) @(negedge clk);
    checks++; if (btn_pulse !== 3'b000) begin errors++; $display("FAIL held_in_rst got %b want 000", btn_pulse); end
    rst = 1'b0;
    pc = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (btn_pulse[1] && pc == 0) pc = c;
    end
    checks++; if (pc != DB + 2) begin errors++; $display("FAIL held_release_pulse got cycle %0d want %0d", pc, DB + 2); end
    buttons = '0;
    repeat (DB + 4) @(negedge clk);
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      checks++; if (state !== ((m_mode == 4) ? 2'd2 : 2'(m_mode))) begin errors++; $display("FAIL rnd_state cyc %0d got %0d model mode %0d", n, state, m_mode); end
      checks++; if (paused !== (m_mode == 4)) begin errors++; $display("FAIL rnd_paused cyc %0d got %0b want %0b", n, paused, m_mode == 4); end
      checks++; if (song_select !== 2'(m_sel)) begin errors++; $display("FAIL rnd_select cyc %0d got %0d want %0d", n, song_select, m_sel); end
      checks++; if (song_confirm !== 2'(m_conf)) begin errors++; $display("FAIL rnd_confirm cyc %0d got %0d want %0d", n, song_confirm, m_conf); end
      checks++; if (confirm_pulse !== m_cp) begin errors++; $display("FAIL rnd_cpulse cyc %0d got %0b want %0b", n, confirm_pulse, m_cp); end
      checks++; if (btn_pulse !== m_pulse) begin errors++; $display("FAIL rnd_btnpulse cyc %0d got %b want %b", n, btn_pulse, m_pulse); end
      rst = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 7) == 0) buttons[$urandom_range(0, NB - 1)] ^= 1'b1;
      if ($urandom_range(0, 24) == 0) finish = ~finish;
    end
    rst = 1'b0;
    buttons = '0;
    finish = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    buttons = '0;
    finish = 1'b0;
    test_reset();
    test_start_confirm();
    test_menu_wrap();
    test_debounce();
    test_pause_finish();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/state_menu_ctrl.md
STATE_MENU_CTRL -- requirements
Module: state_menu_ctrl

Interface
REQ-001 Parameter N_BUTTONS, default 3, number of button inputs; minimum 3; bit 0 = prev, bit 1 = next, bit 2 = select.
REQ-002 Parameter N_SONGS, default 3, number of selectable songs; range 2..15.
REQ-003 Parameter DEBOUNCE_CYCLES, default 4, consecutive stable cycles required to accept a button level change; minimum 1.
REQ-004 Derived SEL_W = clog2(N_SONGS+1), width of the song index.
REQ-005 Port clk, input, 1, single system clock; all logic is on its rising edge.
REQ-006 Port rst, input, 1, synchronous active-high reset.
REQ-007 Port buttons, input, N_BUTTONS, raw asynchronous button levels, active-high.
REQ-008 Port finish, input, 1, song-finished level from the playback engine, synchronous to clk.
REQ-009 Port state, output, 2, current FSM state: 0 START, 1 MENU, 2 PLAY, 3 FINISH; PAUSE is reported as 2 with paused = 1.
REQ-010 Port paused, output, 1, high while the FSM is in PAUSE.
REQ-011 Port song_select, output, SEL_W, currently highlighted song, range 1..N_SONGS.
REQ-012 Port song_confirm, output, SEL_W, confirmed song; 0 when no song is confirmed.
REQ-013 Port confirm_pulse, output, 1, one-cycle strobe in the cycle song_confirm is loaded.
REQ-014 Port btn_pulse, output, N_BUTTONS, one-cycle press strobe per button, after debounce.

Function
REQ-015 Each button shall pass through a 2-flop synchroniser, then a per-button debounce counter.
REQ-016 The debounce counter shall clear whenever the synchronised level equals the stable level.
REQ-017 The stable level shall flip when the counter reaches DEBOUNCE_CYCLES consecutive differing cycles, and the counter shall then clear.
REQ-018 btn_pulse[i] shall be high for exactly one cycle on a 0->1 flip of stable[i], i.e. DEBOUNCE_CYCLES+2 cycles after the raw input goes and stays high.
REQ-019 A held button shall produce one pulse only.
REQ-020 A glitch shorter than DEBOUNCE_CYCLES cycles shall produce no pulse.
REQ-021 All FSM, selection and confirm registers shall update on the cycle after the btn_pulse that causes them.
REQ-022 Command priority within one cycle shall be select > next > prev; a prev and next pulse in the same cycle shall leave song_select unchanged.
REQ-023 START: any btn_pulse shall transition to MENU; otherwise the FSM stays in START.
REQ-024 MENU, prev: song_select shall decrement, wrapping from 1 to N_SONGS.
REQ-025 MENU, next: song_select shall increment, wrapping from N_SONGS to 1.
REQ-026 MENU, select: the FSM shall go to PLAY, song_confirm shall load song_select, and confirm_pulse shall be high for 1 cycle.
REQ-027 PLAY: finish shall go to FINISH; otherwise a select pulse shall go to PAUSE; finish wins over a simultaneous select.
REQ-028 PAUSE: select shall return to PLAY; finish shall go to FINISH.
REQ-029 FINISH: select shall go to MENU and clear song_confirm to 0; song_select shall be retained.
REQ-030 prev and next shall have no effect outside MENU.
REQ-031 Buttons with index >= 3 shall only produce btn_pulse and shall not affect the FSM.
REQ-032 song_confirm shall hold its value throughout PLAY, PAUSE and FINISH.

Reset
REQ-033 While rst is high: state = START, paused = 0, song_select = 1, song_confirm = 0, confirm_pulse = 0, btn_pulse = 0.
REQ-034 While rst is high, synchronisers, stable levels and debounce counters shall all be cleared to 0.
REQ-035 rst asserted in any state shall return all outputs to their reset values at the next rising edge; a button held through reset release shall produce a pulse after DEBOUNCE_CYCLES+2 cycles.

Verification (N_SONGS = 3, DEBOUNCE_CYCLES = 4)
REQ-036 Start and confirm: after reset, press buttons[0] -> state 1 one cycle after btn_pulse[0]; then press select -> state 2, song_confirm = 1, confirm_pulse high for 1 cycle.
REQ-037 Menu wrap: in MENU with song_select = 1, prev -> 3; next -> 1; next twice -> 3; prev and next in the same cycle -> unchanged.
REQ-038 Debounce: a 3-cycle high glitch -> no btn_pulse; a 6-cycle high -> exactly one pulse, 6 cycles after the rise; a level held 100 cycles -> one pulse.
REQ-039 Pause and finish: in PLAY, select -> paused = 1; select again -> paused = 0; finish together with select in PLAY -> state 3; then select -> state 1, song_confirm = 0, song_select retained.
REQ-040 Reset mid-operation: rst during PAUSE with song_confirm = 2 -> next cycle state 0, paused 0, song_select 1, song_confirm 0.
